// File: rtl/ram_rd_check.sv
// Read-back checker for the 32x8 RAM test pattern (rd_data == {3'b000, addr}).
// Optional status LED blinker is built only when RAM_CHK_LED_EN is defined.
module ram_rd_check #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned BLINK_CNT  = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_en,
  input  logic        ram_wea,
  input  logic [4:0]  ram_addr,
  input  logic [7:0]  ram_rd_data,
  output logic        chk_valid,
  output logic        chk_fail,
  output logic        err_flag,
  output logic [4:0]  err_addr,
  output logic [7:0]  err_cnt,
  output logic [15:0] ok_cnt,
  output logic        led
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         written_q, written_d;
  logic [RD_LATENCY-1:0] pv_q;
  logic [4:0]          pa_q [RD_LATENCY];

  logic        chk_valid_q, chk_valid_d;
  logic        chk_fail_q, chk_fail_d;
  logic        err_flag_q, err_flag_d;
  logic [4:0]  err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;

  logic       wr_ev, rd_ev, out_v, mismatch;
  logic [4:0] out_a;

  assign wr_ev    = ram_en & ram_wea;
  assign rd_ev    = ram_en & ~ram_wea;
  assign out_v    = pv_q[RD_LATENCY-1];
  assign out_a    = pa_q[RD_LATENCY-1];
  assign mismatch = out_v && (ram_rd_data != {3'b000, out_a});

  // Valid bit uses written_q, i.e. the flags as they stood before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pa_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_ev & written_q[ram_addr];
      pa_q[0] <= ram_addr;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  always_comb begin
    written_d   = written_q;
    if (wr_ev) written_d[ram_addr] = 1'b1;
    chk_valid_d = out_v;
    chk_fail_d  = mismatch;
    err_flag_d  = err_flag_q | mismatch;
    err_addr_d  = (mismatch && !err_flag_q) ? out_a : err_addr_q;
    err_cnt_d   = (mismatch && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    ok_cnt_d    = (out_v && !mismatch) ? ok_cnt_q + 16'd1 : ok_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (mismatch) state_d = S_FAIL; else if (wr_ev) state_d = S_RUN;
      S_RUN:   if (mismatch) state_d = S_FAIL;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      written_q   <= '0;
      chk_valid_q <= 1'b0;
      chk_fail_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
      ok_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      written_q   <= written_d;
      chk_valid_q <= chk_valid_d;
      chk_fail_q  <= chk_fail_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
      ok_cnt_q    <= ok_cnt_d;
    end
  end

  assign chk_valid = chk_valid_q;
  assign chk_fail  = chk_fail_q;
  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
  assign ok_cnt    = ok_cnt_q;

`ifdef RAM_CHK_LED_EN
  localparam logic [24:0] BLINK_LAST = 25'(BLINK_CNT - 1);

  logic [24:0] blink_q, blink_d;
  logic        led_q, led_d;

  // Counter idles at 0 outside S_FAIL so each blink phase starts fresh.
  always_comb begin
    blink_d = '0;
    led_d   = 1'b0;
    case (state_q)
      S_RUN: led_d = 1'b1;
      S_FAIL: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          led_d   = ~led_q;
        end else begin
          blink_d = blink_q + 25'd1;
          led_d   = led_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;
`else
  assign led = 1'b0;
`endif

endmodule

// File: doc/ram_rd_check.md
# ram_rd_check

Read-back checker sitting directly downstream of the single-port RAM test stimulus generator and the 32×8 RAM. It snoops the RAM control bus (enable, write-select, address) together with the RAM read data. It tracks which addresses have been written since reset and delays each read request by the RAM read latency. Each returned word is compared against the test pattern `rd_data == {3'b000, addr}`, and the block reports per-read results, error statistics and a status LED.

## Interface
Parameters:
- `RD_LATENCY`, 2: edges from a read request being sampled to `ram_rd_data` being valid; legal range 1..4.
- `BLINK_CNT`, 25_000_000: half-period of the fail blink, in clk cycles.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ram_en`  in  1  RAM enable, as driven to the RAM.
- `ram_wea`  in  1  1 = write, 0 = read (qualified by `ram_en`).
- `ram_addr`  in  5  RAM address.
- `ram_rd_data`  in  8  RAM read data.
- `chk_valid`  out  1  one-cycle pulse: a tracked read was compared.
- `chk_fail`  out  1  one-cycle pulse coincident with `chk_valid` when the compare mismatched.
- `err_flag`  out  1  sticky: at least one mismatch since reset.
- `err_addr`  out  5  address of the first mismatch; holds after that.
- `err_cnt`  out  8  mismatch count, saturates at 255.
- `ok_cnt`  out  16  matching-read count, wraps at 65535→0.
- `led`  out  1  status indicator.

## Operation
- Write event: `ram_en & ram_wea` at an edge. Sets `written[ram_addr]` in a 32-bit flag vector.
- Read event: `ram_en & ~ram_wea` at an edge. Enters a `RD_LATENCY`-deep shift pipeline carrying {valid, addr}. The stage valid bit is `written[ram_addr]`, sampled before that edge's update.
  - Reads of never-written addresses are dropped. They produce no `chk_valid` and are not counted.
- Pipeline output stage valid: compare `ram_rd_data` to `{3'b000, addr_out}`.
  - Match: `ok_cnt += 1`.
  - Mismatch: `err_cnt` increments (saturating at 255) and `err_flag` is set. If this is the first mismatch, `err_addr` captures `addr_out`.
- State machine `state[1:0]`:
  - S_WAIT (reset): no write seen yet. Goes to S_RUN on the first write event.
  - S_RUN: goes to S_FAIL on the first mismatch.
  - S_FAIL: terminal until reset. Checking and counters continue in this state.
- `led` behaviour by state:
  - S_WAIT: 0.
  - S_RUN: 1.
  - S_FAIL: toggles every `BLINK_CNT` cycles, driven by a 25-bit counter that starts from 0 on entry to S_FAIL.
- Back-to-back reads every cycle are supported at full throughput.
- A write and a read cannot coincide; `ram_wea` resolves the cycle.
- A write to address A while a read of A is in flight does not affect that read's check.

## Timing
- Read sampled at edge k → compare at edge k+`RD_LATENCY` → `chk_valid`/`chk_fail` high for exactly one cycle following that edge.
  - Counters, `err_flag`, `err_addr` and `state` update at the same edge.
- `led` lags `state` by one cycle (registered).
- Reset (async assert, synchronous release via flops) takes effect mid-operation:
  - Pipeline is flushed and `written` is cleared.
  - In-flight reads are discarded and never reported.
- Reset values: `chk_valid` 0, `chk_fail` 0, `err_flag` 0, `err_addr` 0, `err_cnt` 0, `ok_cnt` 0, `led` 0, state S_WAIT.
- `ram_en` low: no events. The pipeline keeps shifting, so in-flight reads still complete.

## Configuration
- `RAM_CHK_LED_EN` defined:
  - The blink counter and the `led` register are built as described.
- `RAM_CHK_LED_EN` undefined:
  - The blink counter and the `led` register are removed.
  - `led` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then 64-cycle pattern (32 writes addr=data 0..31, 32 reads 0..31), `RD_LATENCY`=2 → 32 `chk_valid` pulses:
  - First pulse follows the edge 2 cycles after the first read is sampled.
  - `chk_fail` never asserts; `ok_cnt`=32, `err_cnt`=0, state S_RUN, `led`=1.
- Reads of addr 0..31 with no prior write → no `chk_valid`; state S_WAIT; `ok_cnt`=0; `led`=0.
- Full pattern with `ram_rd_data` forced to 8'hFF for the read of addr 5:
  - Exactly one `chk_fail` at that compare edge.
  - `err_addr`=5, `err_cnt`=1, `ok_cnt`=31, state S_FAIL.
  - `led` toggles every `BLINK_CNT` cycles (bench uses `BLINK_CNT`=4).
- `ram_rd_data` stuck at 8'hAA for 300 tracked reads (addr ≠ 8'hAA pattern):
  - `err_cnt` saturates at 255.
  - `err_addr` equals the first failing address.
- `rst_n` pulsed low for 1 cycle during the read phase with 2 reads in flight:
  - All outputs return to reset values and no `chk_valid` follows.
  - Subsequent reads are dropped until new writes occur.
- Build without `RAM_CHK_LED_EN`, rerun the addr-5 failure scenario → `led`=0 throughout; all other outputs match the previous results.
